// File: rtl/alu_serial_seq_if.sv
// Request/response bundle between the control path and the bit-serial ALU sequencer.
// The master issues start/mode/operands; the slave returns ready/done and the results.
interface alu_serial_seq_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [1:0]       mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic [1:0]       cmp_code;

   modport master (
      output start, mode, a, b,
      input  ready, done, result, carry_out, cmp_code
   );

   modport slave (
      input  start, mode, a, b,
      output ready, done, result, carry_out, cmp_code
   );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving a single combinational 1-bit ALU slice: add/sub LSB-first
// with carry/borrow feedback, compare MSB-first with 2-bit state feedback, bitwise AND.
module alu_serial_seq #(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_serial_seq_if.slave   bus,
   output logic              alu_m1,
   output logic              alu_m0,
   output logic              alu_a,
   output logic              alu_b,
   output logic              alu_cin,
   output logic              alu_c1,
   output logic              alu_c0,
   input  logic              alu_f,
   input  logic              alu_cout
);
   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   localparam logic [1:0] MODE_ADD = 2'b00;
   localparam logic [1:0] MODE_SUB = 2'b01;
   localparam logic [1:0] MODE_CMP = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [1:0]       chain_q, chain_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic [1:0]       cmp_q, cmp_d;
   logic             done_q, done_d;
   logic             is_cmp, last_step;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      chain_d   = chain_q;
      mode_d    = mode_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      carry_d   = carry_q;
      cmp_d     = cmp_q;
      done_d    = (state_q == S_DONE);
      alu_m1    = 1'b0;
      alu_m0    = 1'b0;
      alu_a     = 1'b0;
      alu_b     = 1'b0;
      alu_cin   = 1'b0;
      alu_c1    = 1'b0;
      alu_c0    = 1'b0;
      is_cmp    = (mode_q == MODE_CMP);
      last_step = is_cmp ? (idx_q == '0) : (idx_q == LAST);

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d  = S_RUN;
               a_d      = bus.a;
               b_d      = bus.b;
               mode_d   = bus.mode;
               chain_d  = 2'b00;
               idx_d    = (bus.mode == MODE_CMP) ? LAST : '0;
               result_d = '0;
               carry_d  = 1'b0;
               cmp_d    = 2'b00;
            end
         end
         S_RUN: begin
            alu_m1 = mode_q[1];
            alu_m0 = mode_q[0];
            alu_a  = a_q[idx_q];
            alu_b  = b_q[idx_q];
            case (mode_q)
               MODE_ADD, MODE_SUB: begin
                  alu_cin         = chain_q[0];
                  result_d[idx_q] = alu_f;
                  chain_d[0]      = alu_cout;
                  if (last_step) carry_d = alu_cout;
               end
               MODE_CMP: begin
                  // slice reports the running verdict on {F, Cout}; feed it back unmodified
                  alu_c1  = chain_q[1];
                  alu_c0  = chain_q[0];
                  chain_d = {alu_f, alu_cout};
                  if (last_step) cmp_d = {alu_f, alu_cout};
               end
               default: result_d[idx_q] = alu_f;
            endcase
            if (last_step) state_d = S_DONE;
            else           idx_d   = is_cmp ? idx_q - 1'b1 : idx_q + 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         chain_q  <= 2'b00;
         mode_q   <= 2'b00;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         cmp_q    <= 2'b00;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         chain_q  <= chain_d;
         mode_q   <= mode_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         cmp_q    <= cmp_d;
         done_q   <= done_d;
      end
   end

   assign bus.ready     = (state_q == S_IDLE);
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.carry_out = carry_q;
   assign bus.cmp_code  = cmp_q;
endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq: behavioural 1-bit slice, vector table, scoreboard on done.
module tb_alu_serial_seq;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_serial_seq_if #(.WIDTH(W)) bus ();
   logic alu_m1, alu_m0, alu_a, alu_b, alu_cin, alu_c1, alu_c0, alu_f, alu_cout;

   alu_serial_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .alu_m1(alu_m1), .alu_m0(alu_m0), .alu_a(alu_a), .alu_b(alu_b),
      .alu_cin(alu_cin), .alu_c1(alu_c1), .alu_c0(alu_c0),
      .alu_f(alu_f), .alu_cout(alu_cout)
   );

   // behavioural 1-bit ALU slice
   always_comb begin
      alu_f    = 1'b0;
      alu_cout = 1'b0;
      case ({alu_m1, alu_m0})
         2'b00: begin
            alu_f    = alu_a ^ alu_b ^ alu_cin;
            alu_cout = (alu_a & alu_b) | (alu_cin & (alu_a ^ alu_b));
         end
         2'b01: begin
            alu_f    = alu_a ^ alu_b ^ alu_cin;
            alu_cout = (~alu_a & alu_b) | (~(alu_a ^ alu_b) & alu_cin);
         end
         2'b10: begin
            if ({alu_c1, alu_c0} != 2'b00) {alu_f, alu_cout} = {alu_c1, alu_c0};
            else {alu_f, alu_cout} = {alu_a & ~alu_b, ~alu_a & alu_b};
         end
         default: alu_f = alu_a & alu_b;
      endcase
   end

   typedef struct {
      logic [1:0]   mode;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         co;
      logic [1:0]   cmp;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic         co;
      logic [1:0]   cmp;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   vec_t cur;
   int   n_vec = 0, n_err = 0, cyc = 0, done_cnt = 0, acc_cnt = 0, prev_acc = 0, b2b_n = 0;
   bit   b2b_chk = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard: push on accepted start, pop and compare on done
   always @(negedge clk) begin
      if (!rst_n) exp_q.delete();
      else begin
         if (bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_done: got done=1 expected no pending op at cycle %0d", cyc);
            end else begin
               e = exp_q.pop_front();
               check("result", bus.result, e.res);
               check("carry_out", bus.carry_out, e.co);
               check("cmp_code", bus.cmp_code, e.cmp);
               check("latency", cyc - e.cyc, W + 2);
            end
         end
         if (bus.start && bus.ready) begin
            if (b2b_chk) begin
               if (b2b_n > 0) check("b2b_interval", cyc - prev_acc, W + 2);
               b2b_n++;
            end
            prev_acc = cyc;
            acc_cnt++;
            exp_q.push_back('{res: cur.res, co: cur.co, cmp: cur.cmp, cyc: cyc});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v);
      cur       = v;
      bus.mode  = v.mode;
      bus.a     = v.a;
      bus.b     = v.b;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int n = 0;
      while (done_cnt == d0 && n < 30) begin
         tick();
         n++;
      end
      if (done_cnt == d0) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: got no done expected done within 30 cycles");
      end
      tick();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ready"}, bus.ready, 1);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_result"}, bus.result, 0);
      check({tag, "_alu"}, {alu_m1, alu_m0, alu_a, alu_b, alu_cin, alu_c1, alu_c0}, 0);
   endtask

   vec_t tbl[8];

   initial begin
      int d0, a0, n;
      tbl[0] = '{2'b00, 4'b0111, 4'b0011, 4'b1010, 1'b0, 2'b00};
      tbl[1] = '{2'b00, 4'b1111, 4'b0001, 4'b0000, 1'b1, 2'b00};
      tbl[2] = '{2'b01, 4'b0101, 4'b0011, 4'b0010, 1'b0, 2'b00};
      tbl[3] = '{2'b01, 4'b0011, 4'b0101, 4'b1110, 1'b1, 2'b00};
      tbl[4] = '{2'b10, 4'b1001, 4'b0110, 4'b0000, 1'b0, 2'b10};
      tbl[5] = '{2'b10, 4'b0110, 4'b0111, 4'b0000, 1'b0, 2'b01};
      tbl[6] = '{2'b10, 4'b1010, 4'b1010, 4'b0000, 1'b0, 2'b00};
      tbl[7] = '{2'b11, 4'b1100, 4'b1010, 4'b1000, 1'b0, 2'b00};

      bus.start = 1'b0;
      bus.mode  = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      cur       = tbl[0];
      repeat (3) tick();
      check_idle_outputs("reset");
      check("reset_carry", bus.carry_out, 0);
      check("reset_cmp", bus.cmp_code, 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         d0 = done_cnt;
         apply(tbl[i]);
         wait_done(d0);
      end

      // compare: MSB first, slice verdict fed back on c1/c0
      d0 = done_cnt;
      apply('{2'b10, 4'b1001, 4'b0110, 4'b0000, 1'b0, 2'b10});
      check("cmp_ready_busy", bus.ready, 0);
      check("cmp_step0_drive", {alu_m1, alu_m0, alu_a, alu_b, alu_cin, alu_c1, alu_c0}, 7'b1010000);
      tick();
      check("cmp_step1_drive", {alu_m1, alu_m0, alu_a, alu_b, alu_cin, alu_c1, alu_c0}, 7'b1001010);
      wait_done(d0);

      // AND result from above table entry is replaced: results clear on accept, carry chains LSB first
      d0 = done_cnt;
      apply(tbl[7]);
      wait_done(d0);
      d0 = done_cnt;
      apply('{2'b00, 4'b0001, 4'b0001, 4'b0010, 1'b0, 2'b00});
      check("clear_on_accept", bus.result, 0);
      check("add_step0_drive", {alu_m1, alu_m0, alu_a, alu_b, alu_cin, alu_c1, alu_c0}, 7'b0011000);
      tick();
      check("add_step1_drive", {alu_m1, alu_m0, alu_a, alu_b, alu_cin, alu_c1, alu_c0}, 7'b0000100);
      wait_done(d0);
      repeat (3) tick();
      check("hold_result", bus.result, 4'b0010);

      // start during RUN is ignored
      d0 = done_cnt;
      apply(tbl[7]);
      tick();
      bus.a     = 4'b0111;
      bus.b     = 4'b0111;
      bus.mode  = 2'b00;
      bus.start = 1'b1;
      check("busy_ready", bus.ready, 0);
      tick();
      bus.start = 1'b0;
      wait_done(d0);
      check("busy_ready_after", bus.ready, 1);

      // reset on the second RUN cycle
      apply('{2'b00, 4'b0111, 4'b0011, 4'b1010, 1'b0, 2'b00});
      tick();
      rst_n = 1'b0;
      tick();
      check_idle_outputs("midreset");
      rst_n = 1'b1;
      tick();
      d0 = done_cnt;
      apply('{2'b00, 4'b0101, 4'b0110, 4'b1011, 1'b0, 2'b00});
      wait_done(d0);

      // back-to-back with start held high
      d0        = done_cnt;
      a0        = acc_cnt;
      b2b_chk   = 1'b1;
      cur       = '{2'b00, 4'b0011, 4'b0100, 4'b0111, 1'b0, 2'b00};
      bus.mode  = cur.mode;
      bus.a     = cur.a;
      bus.b     = cur.b;
      bus.start = 1'b1;
      n = 0;
      while (acc_cnt < a0 + 3 && n < 60) begin
         tick();
         n++;
      end
      tick();
      bus.start = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         tick();
         n++;
      end
      tick();
      b2b_chk = 1'b0;
      check("b2b_accepts", acc_cnt - a0, 3);
      check("b2b_done_pulses", done_cnt - d0, 3);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
